// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble encoding and flush-tracking states.
package core_pipe_pkg;

   localparam int CTRL_W     = 8;

   localparam int REG_WRITE  = 0;
   localparam int MEM_READ   = 1;
   localparam int MEM_WRITE  = 2;
   localparam int MEM_TO_REG = 3;
   localparam int ALU_SRC    = 4;
   localparam int REG_DST    = 5;
   localparam int ALU_OP_LO  = 6;
   localparam int ALU_OP_HI  = 7;

   localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

   typedef enum logic {
      IDLE          = 1'b0,
      FLUSH_PENDING = 1'b1
   } flush_state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-side inputs, writeback snoop, pipeline control and registered EX-side outputs.
interface id_ex_if
   import core_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int CTRL_W = core_pipe_pkg::CTRL_W,
   parameter int CNT_W  = 16
);
   logic              id_valid_i;
   logic [ADDR_W-1:0] id_rs_i;
   logic [ADDR_W-1:0] id_rt_i;
   logic [ADDR_W-1:0] id_rd_i;
   logic              id_uses_rt_i;
   logic [WIDTH-1:0]  id_imm_i;
   logic [CTRL_W-1:0] id_ctrl_i;
   logic [WIDTH-1:0]  rf_data1_i;
   logic [WIDTH-1:0]  rf_data2_i;
   logic              wb_we_i;
   logic [ADDR_W-1:0] wb_addr_i;
   logic [WIDTH-1:0]  wb_data_i;
   logic              ex_hold_i;
   logic              flush_i;

   logic              stall_o;
   logic              ex_valid_o;
   logic [ADDR_W-1:0] ex_rs_o;
   logic [ADDR_W-1:0] ex_rt_o;
   logic [ADDR_W-1:0] ex_rd_o;
   logic [WIDTH-1:0]  ex_op1_o;
   logic [WIDTH-1:0]  ex_op2_o;
   logic [WIDTH-1:0]  ex_imm_o;
   logic [CTRL_W-1:0] ex_ctrl_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   modport master (
      output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_uses_rt_i, id_imm_i, id_ctrl_i,
             rf_data1_i, rf_data2_i, wb_we_i, wb_addr_i, wb_data_i, ex_hold_i, flush_i,
      input  stall_o, ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_op1_o, ex_op2_o,
             ex_imm_o, ex_ctrl_o, bubble_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_uses_rt_i, id_imm_i, id_ctrl_i,
             rf_data1_i, rf_data2_i, wb_we_i, wb_addr_i, wb_data_i, ex_hold_i, flush_i,
      output stall_o, ex_valid_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_op1_o, ex_op2_o,
             ex_imm_o, ex_ctrl_o, bubble_cnt_o
   );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detection: an instruction in ID sourcing the destination of a load sitting in EX.
module hazard_detect_unit #(
   parameter int ADDR_W = 5
) (
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs,
   input  logic [ADDR_W-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_valid,
   input  logic              ex_mem_read,
   input  logic [ADDR_W-1:0] ex_rt,
   output logic              hazard
);

   logic ex_load;
   logic rs_match;
   logic rt_match;

   // r0 is hardwired to zero, so a load targeting it never creates a dependency
   assign ex_load  = ex_valid & ex_mem_read & (ex_rt != '0);
   assign rs_match = (ex_rt == id_rs);
   assign rt_match = id_uses_rt & (ex_rt == id_rt);
   assign hazard   = id_valid & ex_load & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush (deferred while EX is held) and bubble counter.
// Define ID_EX_WB_BYPASS_EN to forward same-cycle writeback data into the captured operands.
module id_ex_stage
   import core_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5,
   parameter int CTRL_W = core_pipe_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input logic   clk,
   input logic   reset,
   id_ex_if.slave bus
);

   flush_state_t      state;
   flush_state_t      state_next;
   logic              hazard;
   logic              pending_flush;
   logic [WIDTH-1:0]  op1_next;
   logic [WIDTH-1:0]  op2_next;

   logic              ex_valid;
   logic [ADDR_W-1:0] ex_rs;
   logic [ADDR_W-1:0] ex_rt;
   logic [ADDR_W-1:0] ex_rd;
   logic [WIDTH-1:0]  ex_op1;
   logic [WIDTH-1:0]  ex_op2;
   logic [WIDTH-1:0]  ex_imm;
   logic [CTRL_W-1:0] ex_ctrl;
   logic [CNT_W-1:0]  bubble_cnt;

   hazard_detect_unit #(.ADDR_W(ADDR_W)) u_hazard (
      .id_valid    (bus.id_valid_i),
      .id_rs       (bus.id_rs_i),
      .id_rt       (bus.id_rt_i),
      .id_uses_rt  (bus.id_uses_rt_i),
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl[MEM_READ]),
      .ex_rt       (ex_rt),
      .hazard      (hazard)
   );

   assign pending_flush = (state == FLUSH_PENDING);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:          if (bus.ex_hold_i && bus.flush_i) state_next = FLUSH_PENDING;
         FLUSH_PENDING: if (!bus.ex_hold_i)               state_next = IDLE;
         default:       state_next = IDLE;
      endcase
   end

`ifdef ID_EX_WB_BYPASS_EN
   always_comb begin
      op1_next = bus.rf_data1_i;
      op2_next = bus.rf_data2_i;
      if (bus.wb_we_i && (bus.wb_addr_i != '0) && (bus.wb_addr_i == bus.id_rs_i))
         op1_next = bus.wb_data_i;
      if (bus.wb_we_i && (bus.wb_addr_i != '0) && (bus.wb_addr_i == bus.id_rt_i))
         op2_next = bus.wb_data_i;
   end
`else
   // register file writes on the falling edge, so its read data already reflects writeback
   assign op1_next = bus.rf_data1_i;
   assign op2_next = bus.rf_data2_i;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid   <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_imm     <= '0;
         ex_ctrl    <= BUBBLE_CTRL;
         bubble_cnt <= '0;
      end else if (bus.ex_hold_i) begin
         ex_valid   <= ex_valid;
      end else if (bus.flush_i || pending_flush || hazard) begin
         ex_valid   <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_op1     <= '0;
         ex_op2     <= '0;
         ex_imm     <= '0;
         ex_ctrl    <= BUBBLE_CTRL;
         // a flush already produces the bubble, so only pure hazard bubbles are counted
         if (!bus.flush_i && !pending_flush && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
      end else begin
         ex_valid   <= bus.id_valid_i;
         ex_rs      <= bus.id_rs_i;
         ex_rt      <= bus.id_rt_i;
         ex_rd      <= bus.id_rd_i;
         ex_op1     <= op1_next;
         ex_op2     <= op2_next;
         ex_imm     <= bus.id_imm_i;
         ex_ctrl    <= bus.id_valid_i ? bus.id_ctrl_i : BUBBLE_CTRL;
      end
   end

   assign bus.stall_o      = hazard | bus.ex_hold_i;
   assign bus.ex_valid_o   = ex_valid;
   assign bus.ex_rs_o      = ex_rs;
   assign bus.ex_rt_o      = ex_rt;
   assign bus.ex_rd_o      = ex_rd;
   assign bus.ex_op1_o     = ex_op1;
   assign bus.ex_op2_o     = ex_op2;
   assign bus.ex_imm_o     = ex_imm;
   assign bus.ex_ctrl_o    = ex_ctrl;
   assign bus.bubble_cnt_o = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID-side vectors push the expected EX state, a monitor compares it.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_s = 1'b1;
   always #5 clk = ~clk;

   id_ex_if #(.WIDTH(32), .ADDR_W(5), .CTRL_W(8), .CNT_W(16)) bus ();
   id_ex_if #(.WIDTH(32), .ADDR_W(5), .CTRL_W(8), .CNT_W(4))  bus_s ();

   id_ex_stage #(.WIDTH(32), .ADDR_W(5), .CTRL_W(8), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   id_ex_stage #(.WIDTH(32), .ADDR_W(5), .CTRL_W(8), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .reset (rst_s),
      .bus   (bus_s.slave)
   );

`ifdef ID_EX_WB_BYPASS_EN
   localparam bit BYP_ON = 1'b1;
`else
   localparam bit BYP_ON = 1'b0;
`endif

   localparam logic [7:0] C_LW  = 8'h1B;
   localparam logic [7:0] C_ADD = 8'hA1;
   localparam logic [7:0] C_ALU = 8'h11;
   localparam logic [7:0] C_SW  = 8'h14;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] imm;
      logic [7:0]  ctrl;
      logic [15:0] cnt;
      int          sid;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int   checks = 0;
   int   failures = 0;
   int   step_id = 0;

   task automatic chk(input string nm, input int sid, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", nm, sid, act, req);
      end
   endtask

   function automatic exp_t ex(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] imm, input logic [7:0] ctrl, input logic [15:0] cnt);
      exp_t e;
      e = '{valid: v, rs: rs, rt: rt, rd: rd, op1: op1, op2: op2, imm: imm, ctrl: ctrl, cnt: cnt, sid: 0};
      return e;
   endfunction

   function automatic exp_t bub(input logic [15:0] cnt);
      return ex(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 8'd0, cnt);
   endfunction

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic ut, input logic [31:0] imm, input logic [7:0] ctrl,
                         input logic [31:0] d1, input logic [31:0] d2);
      bus.id_valid_i   = v;
      bus.id_rs_i      = rs;
      bus.id_rt_i      = rt;
      bus.id_rd_i      = rd;
      bus.id_uses_rt_i = ut;
      bus.id_imm_i     = imm;
      bus.id_ctrl_i    = ctrl;
      bus.rf_data1_i   = d1;
      bus.rf_data2_i   = d2;
   endtask

   // called just after a falling edge; the expectation describes EX after the next rising edge
   task automatic cyc(input logic r, input logic hold, input logic flush,
                      input logic chk_st, input logic exp_st, input exp_t e);
      exp_t t;
      rst           = r;
      bus.ex_hold_i = hold;
      bus.flush_i   = flush;
      step_id++;
      #1;
      if (chk_st) chk("stall", step_id, 32'(bus.stall_o), 32'(exp_st));
      t = e;
      t.sid = step_id;
      q.push_back(t);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      if (q.size() > 0) begin
         #1;
         m = q.pop_front();
         chk("ex_valid", m.sid, 32'(bus.ex_valid_o), 32'(m.valid));
         chk("ex_rs",    m.sid, 32'(bus.ex_rs_o),    32'(m.rs));
         chk("ex_rt",    m.sid, 32'(bus.ex_rt_o),    32'(m.rt));
         chk("ex_rd",    m.sid, 32'(bus.ex_rd_o),    32'(m.rd));
         chk("ex_op1",   m.sid, bus.ex_op1_o,        m.op1);
         chk("ex_op2",   m.sid, bus.ex_op2_o,        m.op2);
         chk("ex_imm",   m.sid, bus.ex_imm_o,        m.imm);
         chk("ex_ctrl",  m.sid, 32'(bus.ex_ctrl_o),  32'(m.ctrl));
         chk("bubble_cnt", m.sid, 32'(bus.bubble_cnt_o), 32'(m.cnt));
      end
   end

   initial begin
      bus.wb_we_i = 1'b0; bus.wb_addr_i = '0; bus.wb_data_i = '0;
      bus.ex_hold_i = 1'b0; bus.flush_i = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 8'd0, 32'd0, 32'd0);
      bus_s.id_valid_i = 1'b1; bus_s.id_rs_i = 5'd5; bus_s.id_rt_i = 5'd5; bus_s.id_rd_i = 5'd0;
      bus_s.id_uses_rt_i = 1'b0; bus_s.id_imm_i = 32'd0; bus_s.id_ctrl_i = C_LW;
      bus_s.rf_data1_i = 32'd0; bus_s.rf_data2_i = 32'd0;
      bus_s.wb_we_i = 1'b0; bus_s.wb_addr_i = '0; bus_s.wb_data_i = '0;
      bus_s.ex_hold_i = 1'b0; bus_s.flush_i = 1'b0;
      @(negedge clk);

      // reset with junk inputs, including a held flush that reset must not remember
      set_id(1'b1, 5'd3, 5'd5, 5'd7, 1'b1, 32'hFFFF, 8'hFF, 32'hDEAD, 32'hBEEF);
      bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd3; bus.wb_data_i = 32'h5555;
      cyc(1, 1, 1, 0, 0, bub(0));
      cyc(1, 0, 0, 1, 0, bub(0));
      bus.wb_we_i = 1'b0; bus.wb_addr_i = '0; bus.wb_data_i = '0;

      // pass-through
      set_id(1, 5'd3, 5'd4, 5'd6, 1, 32'h10, C_ALU, 32'h1234, 32'h5678);
      cyc(0, 0, 0, 1, 0, ex(1, 3, 4, 6, 32'h1234, 32'h5678, 32'h10, C_ALU, 0));
      // lw r5 then dependent add on rs
      set_id(1, 5'd2, 5'd5, 5'd0, 0, 32'h4, C_LW, 32'h100, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 2, 5, 0, 32'h100, 32'h0, 32'h4, C_LW, 0));
      set_id(1, 5'd5, 5'd6, 5'd7, 1, 32'h0, C_ADD, 32'hAA, 32'hBB);
      cyc(0, 0, 0, 1, 1, bub(1));
      cyc(0, 0, 0, 1, 0, ex(1, 5, 6, 7, 32'hAA, 32'hBB, 32'h0, C_ADD, 1));
      // load into r0 never stalls
      set_id(1, 5'd1, 5'd0, 5'd0, 0, 32'h8, C_LW, 32'h200, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 1, 0, 0, 32'h200, 32'h0, 32'h8, C_LW, 1));
      set_id(1, 5'd0, 5'd0, 5'd9, 1, 32'h0, C_ADD, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 0, 0, 9, 32'h0, 32'h0, 32'h0, C_ADD, 1));
      // rt match only counts when the instruction reads rt
      set_id(1, 5'd1, 5'd8, 5'd0, 0, 32'hC, C_LW, 32'h300, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 1, 8, 0, 32'h300, 32'h0, 32'hC, C_LW, 1));
      set_id(1, 5'd1, 5'd8, 5'd0, 0, 32'h0, C_SW, 32'h300, 32'h55);
      cyc(0, 0, 0, 1, 0, ex(1, 1, 8, 0, 32'h300, 32'h55, 32'h0, C_SW, 1));
      set_id(1, 5'd1, 5'd8, 5'd0, 0, 32'hC, C_LW, 32'h300, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 1, 8, 0, 32'h300, 32'h0, 32'hC, C_LW, 1));
      set_id(1, 5'd2, 5'd8, 5'd3, 1, 32'h0, C_ADD, 32'h11, 32'h22);
      cyc(0, 0, 0, 1, 1, bub(2));
      cyc(0, 0, 0, 1, 0, ex(1, 2, 8, 3, 32'h11, 32'h22, 32'h0, C_ADD, 2));
      // three held cycles, flush in the second, bubble on release
      set_id(1, 5'd4, 5'd5, 5'd6, 1, 32'h1, C_ALU, 32'h44, 32'h55);
      cyc(0, 1, 0, 1, 1, ex(1, 2, 8, 3, 32'h11, 32'h22, 32'h0, C_ADD, 2));
      cyc(0, 1, 1, 1, 1, ex(1, 2, 8, 3, 32'h11, 32'h22, 32'h0, C_ADD, 2));
      cyc(0, 1, 0, 1, 1, ex(1, 2, 8, 3, 32'h11, 32'h22, 32'h0, C_ADD, 2));
      cyc(0, 0, 0, 1, 0, bub(2));
      cyc(0, 0, 0, 1, 0, ex(1, 4, 5, 6, 32'h44, 32'h55, 32'h1, C_ALU, 2));
      // flush coinciding with a hazard: one bubble, no count
      set_id(1, 5'd0, 5'd5, 5'd0, 0, 32'h20, C_LW, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 0, 5, 0, 32'h0, 32'h0, 32'h20, C_LW, 2));
      set_id(1, 5'd5, 5'd6, 5'd7, 1, 32'h0, C_ADD, 32'hAA, 32'hBB);
      cyc(0, 0, 1, 1, 1, bub(2));
      set_id(1, 5'd3, 5'd4, 5'd5, 1, 32'h2, C_ALU, 32'h66, 32'h77);
      cyc(0, 0, 1, 1, 0, bub(2));
      // invalid ID slot: fields captured, control zeroed
      set_id(0, 5'd1, 5'd2, 5'd3, 1, 32'hB, 8'hFF, 32'h9, 32'hA);
      cyc(0, 0, 0, 1, 0, ex(0, 1, 2, 3, 32'h9, 32'hA, 32'hB, 8'h00, 2));
      set_id(1, 5'd0, 5'd5, 5'd0, 0, 32'h20, C_LW, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 0, 5, 0, 32'h0, 32'h0, 32'h20, C_LW, 2));
      set_id(0, 5'd5, 5'd5, 5'd1, 1, 32'h3, C_ADD, 32'h1, 32'h2);
      cyc(0, 0, 0, 1, 0, ex(0, 5, 5, 1, 32'h1, 32'h2, 32'h3, 8'h00, 2));
      // hold over a hazard keeps EX and does not count
      set_id(1, 5'd0, 5'd5, 5'd0, 0, 32'h20, C_LW, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 0, 5, 0, 32'h0, 32'h0, 32'h20, C_LW, 2));
      set_id(1, 5'd5, 5'd6, 5'd7, 1, 32'h0, C_ADD, 32'hAA, 32'hBB);
      cyc(0, 1, 0, 1, 1, ex(1, 0, 5, 0, 32'h0, 32'h0, 32'h20, C_LW, 2));
      cyc(0, 0, 0, 1, 1, bub(3));
      cyc(0, 0, 0, 1, 0, ex(1, 5, 6, 7, 32'hAA, 32'hBB, 32'h0, C_ADD, 3));
      // writeback forwarding
      bus.wb_we_i = 1'b1; bus.wb_addr_i = 5'd7; bus.wb_data_i = 32'hCAFE;
      set_id(1, 5'd7, 5'd7, 5'd1, 1, 32'h0, C_ADD, 32'h0, 32'h0);
      cyc(0, 0, 0, 1, 0, ex(1, 7, 7, 1, BYP_ON ? 32'hCAFE : 32'h0, BYP_ON ? 32'hCAFE : 32'h0,
                           32'h0, C_ADD, 3));
      set_id(1, 5'd7, 5'd3, 5'd1, 1, 32'h0, C_ADD, 32'h31, 32'h32);
      cyc(0, 0, 0, 1, 0, ex(1, 7, 3, 1, BYP_ON ? 32'hCAFE : 32'h31, 32'h32, 32'h0, C_ADD, 3));
      bus.wb_addr_i = 5'd0; bus.wb_data_i = 32'hBEEF;
      set_id(1, 5'd0, 5'd0, 5'd1, 1, 32'h0, C_ADD, 32'h1, 32'h2);
      cyc(0, 0, 0, 1, 0, ex(1, 0, 0, 1, 32'h1, 32'h2, 32'h0, C_ADD, 3));
      bus.wb_we_i = 1'b0;

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end

      // saturation on the narrow-counter instance: load and hazard alternate every cycle
      @(negedge clk);
      rst_s = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("sat_cnt_mid", 0, 32'(bus_s.bubble_cnt_o), 32'd10);
      repeat (25) @(posedge clk);
      #1;
      chk("sat_cnt_final", 0, 32'(bus_s.bubble_cnt_o), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the register file in the 5-stage core.
- Captures both register read ports, the decoded fields and the control bundle into the ID/EX register.
- Detects load-use hazards, inserts bubbles and stalls PC/IF-ID.
- Handles branch flush, including a flush that arrives while EX is held, and counts inserted bubbles.

Parameters:
WIDTH, 32, data width of operands and immediate
ADDR_W, 5, register address width (log2 of 32 registers)
CTRL_W, 8, width of control bundle (layout in package)
CNT_W, 16, width of bubble counter

Ports:
- Clocking and reset (decided): one clock; reset is synchronous and active-high. Ports are named clk and reset.
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
id_valid_i  input  1  IF/ID holds a real instruction
id_rs_i  input  ADDR_W  rs field, also drives register file readAddr1
id_rt_i  input  ADDR_W  rt field, also drives register file readAddr2
id_rd_i  input  ADDR_W  rd field
id_uses_rt_i  input  1  instruction reads rt as a source
id_imm_i  input  WIDTH  sign-extended immediate
id_ctrl_i  input  CTRL_W  decoded control bundle
rf_data1_i  input  WIDTH  register file readData1
rf_data2_i  input  WIDTH  register file readData2
wb_we_i  input  1  writeback write enable (same as register file writeEnable)
wb_addr_i  input  ADDR_W  writeback address
wb_data_i  input  WIDTH  writeback data
ex_hold_i  input  1  downstream busy; freeze ID/EX
flush_i  input  1  branch/jump taken; kill instruction in ID
stall_o  output  1  hold PC and IF/ID this cycle
ex_valid_o  output  1  ID/EX holds a real instruction
ex_rs_o, ex_rt_o, ex_rd_o  output  ADDR_W each  registered fields
ex_op1_o, ex_op2_o  output  WIDTH each  registered operands
ex_imm_o  output  WIDTH  registered immediate
ex_ctrl_o  output  CTRL_W  registered control; all zero for a bubble
bubble_cnt_o  output  CNT_W  saturating count of hazard bubbles

Behaviour:
- Reset: all registered outputs are 0, pending_flush is 0 and bubble_cnt_o is 0. Reset overrides every other input.
- Latency: one cycle from the ID inputs to the ex_* outputs.
- hazard (combinational):
  - Requires id_valid_i, ex_valid_o and ex_ctrl_o.MEM_READ all true, and ex_rt_o != 0.
  - Also requires ex_rt_o == id_rs_i, or (id_uses_rt_i and ex_rt_o == id_rt_i).
- stall_o = hazard | ex_hold_i. Purely combinational with no registered delay.
- Per-cycle update, highest priority first:
  1. reset.
  2. ex_hold_i: all ex_* outputs hold. If flush_i is high, pending_flush is set to 1.
  3. flush_i or pending_flush: load a bubble (ex_valid_o=0, ex_ctrl_o=0, remaining data fields 0). Clear pending_flush.
  4. hazard: load a bubble. bubble_cnt_o increments, saturating at all-ones.
  5. Otherwise load ID into EX. ex_valid_o takes id_valid_i. ex_ctrl_o takes id_ctrl_i when id_valid_i is 1, otherwise 0.
- State: pending_flush is a single flop with two states, IDLE and FLUSH_PENDING.
  - IDLE -> FLUSH_PENDING on hold&flush.
  - FLUSH_PENDING -> IDLE on the first cycle with no hold.
- A hazard bubble lasts exactly one cycle: the bubble clears MEM_READ in EX, which drops hazard on the next cycle.
- Register 0: never matches for hazard or bypass.
- A flush coinciding with a hazard yields a single bubble and does not increment the counter.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- Defined: each operand independently takes wb_data_i instead of the rf value when wb_we_i=1, wb_addr_i != 0 and wb_addr_i equals that operand's source address (rs for op1, rt for op2).
- Not defined: operands come straight from rf_data1_i/rf_data2_i. The design then relies on the register file writing on the falling edge so that the value is visible in the same cycle.

Decomposition:
- Package core_pipe_pkg holds:
  - the control-bundle bit indices (REG_WRITE=0, MEM_READ=1, MEM_WRITE=2, MEM_TO_REG=3, ALU_SRC=4, REG_DST=5, ALU_OP=7:6);
  - CTRL_W;
  - a BUBBLE_CTRL constant equal to all zeros.
- One sub-module, hazard_detect_unit: purely combinational, outputs hazard. Register logic, flush flop and counter stay in id_ex_stage.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary inputs -> every output is 0 and stall_o=0.
- Pass-through: id_rs=3, rf_data1=0x1234, ctrl=0x11 -> after 1 cycle ex_op1_o=0x1234, ex_ctrl_o=0x11, ex_valid_o=1.
- Load-use: lw into r5, then add using rs=5 -> stall_o=1 for exactly 1 cycle, one bubble inserted, bubble_cnt_o=1, the add enters EX on the following cycle; a dependency on r0 -> no stall.
- Hold with flush:
  - Stimulus: ex_hold_i=1 for 3 cycles, flush_i pulsed in the 2nd held cycle.
  - Response: EX outputs frozen throughout; on the first unheld cycle a bubble loads and pending_flush clears.
- Bypass (macro defined): wb_we=1, wb_addr=7, wb_data=0xCAFE, id_rs=id_rt=7, rf_data=0 -> ex_op1_o=ex_op2_o=0xCAFE. Same stimulus with the macro undefined -> 0.
- Counter saturation: CNT_W=4, force 20 hazards -> bubble_cnt_o stays at 0xF.
